// File: rtl/imem_server_if.sv
// imem_server_if: load channel and core fetch/reset pins of the instruction-memory server.
// The slave side is imem_server. The master side is the host/bench, which also drives
// the core-facing inputs.
interface imem_server_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic [31:0] core_raddr;
  logic [31:0] core_instr;
  logic        core_reset;
  logic        core_halted;

  modport master (
    output load_valid, load_data, load_last, core_raddr, core_halted,
    input  load_ready, core_instr, core_reset
  );

  modport slave (
    input  load_valid, load_data, load_last, core_raddr, core_halted,
    output load_ready, core_instr, core_reset
  );
endinterface

// File: rtl/imem_server.sv
// imem_server: instruction memory, program loader and run-cycle counter for the
// single-cycle MIPS32 core.
//
// Operation:
//   - Programs stream in over a valid/ready channel.
//   - The core is held in reset for RESET_HOLD cycles after the last word arrives.
//   - Fetches are then served combinationally.
//   - Run cycles are counted until the core raises halted.
//
// Optional feature: define IMEM_BOUNDS_CHECK_EN to enable the bounds check.
//   - Fetches at or beyond words_loaded return a break (0x0000000D).
//   - Such a fetch sampled in RUN sets the sticky fault flag.
module imem_server #(
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 3
) (
  input  logic              clock,
  input  logic              reset,
  imem_server_if.slave      bus,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       cycle_count,
  output logic              done,
  output logic              fault
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {LOAD, HOLD, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         mem [DEPTH];
  logic [3:0]          hold_cnt;
  logic                load_ready_q;
  logic                core_reset_q;
  logic                xfer;
  logic                full_hit;
  logic [ADDR_W-1:0]   wptr;
  logic                oob;

  // The write pointer is simply the low bits of the accepted-word count.
  assign wptr     = words_loaded[ADDR_W-1:0];
  assign xfer     = bus.load_valid & load_ready_q;
  assign full_hit = (wptr == {ADDR_W{1'b1}});

  assign bus.load_ready = load_ready_q;
  assign bus.core_reset = core_reset_q;

`ifdef IMEM_BOUNDS_CHECK_EN
  // Full-width compare, so high address bits can never alias into the program.
  assign oob = (bus.core_raddr >= 32'(words_loaded));
`else
  // Upper address bits are deliberately ignored when the check is not built in.
  logic unused_raddr_hi;
  assign unused_raddr_hi = ^bus.core_raddr[31:ADDR_W];
  assign oob = 1'b0;
`endif

  // Next-state logic.
  //   - HOLD leaves when the down-counter is about to hit 0, so core_reset drops
  //     exactly RESET_HOLD edges after the final load transfer.
  //   - A transfer that fills the last location ends loading regardless of load_last.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (xfer && (bus.load_last || full_hit)) state_d = HOLD;
      HOLD:    if (hold_cnt == 4'd1) state_d = RUN;
      RUN:     if (bus.core_halted) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  // State register plus registered status outputs.
  //   - Reset beats a simultaneous load transfer.
  //   - Outputs are decoded from the next state, so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LOAD;
      load_ready_q <= 1'b1;
      core_reset_q <= 1'b1;
      words_loaded <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      fault        <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= (state_d == LOAD);
      core_reset_q <= (state_d == LOAD) || (state_d == HOLD);
      done         <= (state_d == DONE);

      if (xfer) words_loaded <= words_loaded + (ADDR_W+1)'(1);

      // Preload the hold count while loading, so it holds RESET_HOLD on HOLD entry.
      if (state_q == LOAD)      hold_cnt <= 4'(RESET_HOLD);
      else if (state_q == HOLD) hold_cnt <= hold_cnt - 4'd1;

      // The halting cycle itself is not counted; the counter saturates instead of wrapping.
      if (state_q == RUN && !bus.core_halted && cycle_count != 32'hFFFF_FFFF)
        cycle_count <= cycle_count + 32'd1;

`ifdef IMEM_BOUNDS_CHECK_EN
      if (state_q == RUN && oob) fault <= 1'b1;
`else
      fault <= 1'b0;
`endif
    end
  end

  // Program storage. It has no reset, so old contents survive until overwritten.
  always_ff @(posedge clock) begin
    if (!reset && xfer) mem[wptr] <= bus.load_data;
  end

  // Combinational fetch. Out-of-program addresses return break when the check is built in.
  always_comb begin
    bus.core_instr = mem[bus.core_raddr[ADDR_W-1:0]];
    if (oob) bus.core_instr = 32'h0000_000D;
  end

endmodule

// File: tb/tb_imem_server.sv
// tb_imem_server: self-checking bench for imem_server.
// Instances:
//   - Main instance: ADDR_W=8, with a tiny core model that walks pc and halts on break.
//   - Second instance: ADDR_W=4, for the memory-full case.
// Scoreboard:
//   - Accepted load words are pushed when driven.
//   - They are popped and compared via fetch reads.
module tb_imem_server;

  logic        clock;
  logic        reset;
  logic [8:0]  wl;
  logic [31:0] cc;
  logic        done, fault;
  logic [4:0]  s_wl;
  logic [31:0] s_cc;
  logic        s_done, s_fault;

  imem_server_if bus ();
  imem_server_if sbus ();

  imem_server #(.ADDR_W(8), .RESET_HOLD(3)) u_dut (
    .clock(clock), .reset(reset), .bus(bus),
    .words_loaded(wl), .cycle_count(cc), .done(done), .fault(fault)
  );

  imem_server #(.ADDR_W(4), .RESET_HOLD(3)) u_small (
    .clock(clock), .reset(reset), .bus(sbus),
    .words_loaded(s_wl), .cycle_count(s_cc), .done(s_done), .fault(s_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core model: pc is held at 0 in reset, then advances until a break is fetched.
  logic [31:0] pc_w;
  logic        sel_core;
  logic [31:0] tb_raddr;

  always @(posedge clock) begin
    if (bus.core_reset) pc_w <= 32'd0;
    else if (!bus.core_halted) pc_w <= pc_w + 32'd1;
  end

  assign bus.core_raddr  = sel_core ? pc_w : tb_raddr;
  assign bus.core_halted = sel_core & ~bus.core_reset & (bus.core_instr == 32'h0000_000D);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t vec[4];
  int   n_pass, n_total;
  int   exp_wl;
  bit   loading;

  function automatic logic [31:0] cdat(input int i);
    return 32'hC000_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Offer one word for a cycle. Bench model: accepted while loading and not full.
  task automatic offer(input logic [31:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    if (loading && exp_wl < 256) begin
      sb.push_back('{32'(exp_wl), d});
      exp_wl++;
      if (last || exp_wl == 256) loading = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    sel_core       = 1'b0;
    bus.load_valid = 1'b0;
    reset          = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    exp_wl  = 0;
    loading = 1'b1;
    sb.delete();
  endtask

  // Pop every expected word and compare it against a fetch read.
  task automatic drain(input string name);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tb_raddr = e.addr;
      #1;
      check(name, bus.core_instr, e.data);
    end
  endtask

  task automatic run_core(input string name);
    int k;
    k = 0;
    while (bus.core_reset && k < 20) begin @(negedge clock); k++; end
    sel_core = 1'b1;
    k = 0;
    while (!done && k < 50) begin @(negedge clock); k++; end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    n_pass = 0; n_total = 0;

    // Fetch vectors over the 10-word program of the toggle test.
    vec[0] = '{32'd0,     cdat(0)};
    vec[1] = '{32'd5,     cdat(5)};
    vec[2] = '{32'd9,     cdat(9)};
`ifdef IMEM_BOUNDS_CHECK_EN
    vec[3] = '{32'h103,   32'h0000_000D};
`else
    vec[3] = '{32'h103,   cdat(3)};
`endif

    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    sbus.load_valid = 1'b0; sbus.load_data = '0; sbus.load_last = 1'b0;
    sbus.core_raddr = '0; sbus.core_halted = 1'b0;
    sel_core = 1'b0; tb_raddr = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_core_reset", 32'(bus.core_reset), 32'd1);
    check("rst_wl", 32'(wl), 32'd0);
    check("rst_cc", cc, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_s_wl", 32'(s_wl), 32'd0);
    reset = 1'b0; exp_wl = 0; loading = 1'b1;

    // 3-word program with valid held high
    offer(32'h2001_0005, 1'b0);
    offer(32'h2002_0004, 1'b0);
    offer(32'h0000_000D, 1'b1);
    bus.load_valid = 1'b0;
    check("a_wl", 32'(wl), 32'd3);
    check("a_ready", 32'(bus.load_ready), 32'd0);
    check("a_core_reset_t0", 32'(bus.core_reset), 32'd1);
    @(negedge clock);
    check("a_core_reset_t1", 32'(bus.core_reset), 32'd1);
    @(negedge clock);
    check("a_core_reset_t2", 32'(bus.core_reset), 32'd1);
    @(negedge clock);
    check("a_core_reset_t3", 32'(bus.core_reset), 32'd0);
    run_core("a");
    check("a_cycles", cc, 32'd2);
    repeat (3) @(negedge clock);
    check("a_cycles_frozen", cc, 32'd2);
    check("a_fault", 32'(fault), 32'd0);
    sel_core = 1'b0;
    drain("a_mem");

    // 10 words, valid toggling on alternate cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      offer(cdat(i), i == 9);
      bus.load_valid = 1'b0;
      @(negedge clock);
    end
    check("c_wl", 32'(wl), 32'd10);
    check("c_ready", 32'(bus.load_ready), 32'd0);
    drain("c_mem");
    for (int i = 0; i < 4; i++) begin
      tb_raddr = vec[i].raddr;
      #1;
      check("c_fetch_vec", bus.core_instr, vec[i].exp);
    end

    // Reset after 5 of 8 words; reset coincides with an offered word
    do_reset();
    for (int i = 0; i < 5; i++) offer(32'hB0 + 32'(i), 1'b0);
    bus.load_valid = 1'b1; bus.load_data = 32'hDEAD_BEEF; bus.load_last = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; bus.load_valid = 1'b0;
    exp_wl = 0; loading = 1'b1; sb.delete();
    check("d_wl_after_rst", 32'(wl), 32'd0);
    check("d_ready_after_rst", 32'(bus.load_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      offer(32'hA0 + 32'(i), i == 7);
      check("d_wl_count", 32'(wl), 32'(i + 1));
    end
    bus.load_valid = 1'b0;
    check("d_core_reset_t0", 32'(bus.core_reset), 32'd1);
    repeat (2) @(negedge clock);
    check("d_core_reset_t2", 32'(bus.core_reset), 32'd1);
    @(negedge clock);
    check("d_core_reset_t3", 32'(bus.core_reset), 32'd0);
    drain("d_mem");

`ifdef IMEM_BOUNDS_CHECK_EN
    // Two nops: the fetch at address 2 is out of program and must act as break
    do_reset();
    offer(32'h0, 1'b0);
    offer(32'h0, 1'b1);
    bus.load_valid = 1'b0;
    run_core("e");
    check("e_fault", 32'(fault), 32'd1);
    check("e_cycles", cc, 32'd2);
    sel_core = 1'b0;
    tb_raddr = 32'd2;
    #1;
    check("e_oob_instr", bus.core_instr, 32'h0000_000D);
`endif

    // ADDR_W=4: stream 20 words without last; only 16 may be taken
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sbus.load_valid = 1'b1;
      sbus.load_data  = 32'h5000 + 32'(i);
      sbus.load_last  = 1'b0;
      @(negedge clock);
    end
    sbus.load_valid = 1'b0;
    check("b_wl", 32'(s_wl), 32'd16);
    check("b_ready", 32'(sbus.load_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      sbus.core_raddr = 32'(i);
      #1;
      check("b_mem", sbus.core_instr, 32'h5000 + 32'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder and program loader for the single-cycle MIPS32 core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and holds the core in reset until loading finishes. It then serves the core's word-addressed fetches combinationally and counts run cycles until the core reports halt. It sits between the testbench/host load channel and the core's `raddr`/`instr`/`reset`/`halted` pins.

## Interface
- `ADDR_W`, 8: log2 of memory depth in 32-bit words (default 256 words).
- `RESET_HOLD`, 3: cycles `core_reset` stays high after loading completes; legal range 1..15.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `load_valid`  in  1  load word present.
- `load_ready`  out  1  block accepts a load word.
- `load_data`  in  32  instruction word; written at the next sequential word address.
- `load_last`  in  1  marks the final word of the program.
- `core_raddr`  in  32  word address from the core (pc >> 2).
- `core_instr`  out  32  instruction for `core_raddr`.
- `core_reset`  out  1  reset to the core, synchronous, active-high.
- `core_halted`  in  1  halt flag from the core.
- `words_loaded`  out  ADDR_W+1  number of words accepted.
- `cycle_count`  out  32  RUN cycles elapsed before halt.
- `done`  out  1  core has halted; result is frozen.
- `fault`  out  1  sticky out-of-program fetch flag (see Configuration).

## Operation
- FSM states: LOAD, HOLD, RUN, DONE.
- LOAD:
  - `load_ready`=1, `core_reset`=1.
  - Transfer occurs when `load_valid & load_ready`: mem[wptr] <= `load_data`, and `wptr`/`words_loaded` increment.
  - Go to HOLD on a transfer with `load_last`=1, or on the transfer that fills location 2^ADDR_W-1, whichever comes first. When full, `load_last` is ignored.
  - A zero-word program is impossible; at least one transfer is required to leave LOAD.
- HOLD:
  - `load_ready`=0, `core_reset`=1.
  - A 4-bit counter loads RESET_HOLD on entry and decrements each cycle. The FSM goes to RUN when the counter reaches 0.
- RUN:
  - `core_reset`=0.
  - `cycle_count` increments each cycle in which `core_halted`=0, saturating at 0xFFFF_FFFF.
  - Go to DONE when `core_halted`=1.
- DONE:
  - `done`=1, `core_reset`=0, `cycle_count` frozen.
  - Leaves DONE only on `reset`.
- Fetch path:
  - `core_instr` = mem[`core_raddr`[ADDR_W-1:0]], combinational in every state.
  - Upper address bits are ignored unless the bounds check is compiled in.
- Load-channel words offered outside LOAD are not accepted (`load_ready`=0) and are not written.

## Timing
- Reset values:
  - State LOAD, `load_ready`=1, `core_reset`=1.
  - `words_loaded`=0, `cycle_count`=0, `done`=0, `fault`=0.
  - Memory contents are not cleared.
- Reset taken mid-load, mid-run, or in DONE restarts loading at address 0. Old contents remain until overwritten.
- `load_ready`, `core_reset`, `done`, `fault` and the counters are registered. `load_ready` never depends on `load_valid`.
- A word accepted at edge T is readable on `core_instr` after edge T.
- If the last word is accepted at edge T:
  - HOLD is entered at T.
  - `core_reset` is high through edge T+RESET_HOLD and low from T+RESET_HOLD.
  - The core's first fetch (address 0) executes at edge T+RESET_HOLD+1.
- `core_halted` high at edge H: `done`=1 after H, and `cycle_count` excludes that cycle.
- Simultaneous `reset` and a load transfer: reset wins and the transfer is dropped.

## Configuration
- `IMEM_BOUNDS_CHECK_EN` defined:
  - A fetch with `core_raddr` >= `words_loaded` (full 32-bit unsigned compare) returns 0x0000_000D (break), so a runaway core halts.
  - Such a fetch sampled at a clock edge in RUN sets `fault` (sticky until reset).
- Not defined:
  - Fetches return raw memory for the low ADDR_W bits.
  - `fault` is tied to 0.

## Test plan
- Load 3 words 0x20010005, 0x20020004, 0x0000000D (last on word 3), `load_valid` held high:
  - `words_loaded`=3 and `load_ready`=0 one edge after the third transfer.
  - `core_reset` falls exactly RESET_HOLD=3 edges later.
- Same program run on the core:
  - `done`=1 and `cycle_count`=2 after the break is fetched.
- Toggle `load_valid` 1/0 on alternate cycles while loading 10 words:
  - Exactly 10 writes, at addresses 0..9; no word is dropped or duplicated.
- ADDR_W=4, stream 20 words with `load_last`=0:
  - Transfer stops at 16.
  - `words_loaded`=16; words 17..20 are not accepted.
- Assert `reset` after 5 of 8 words, then reload 8 words 0xA0..0xA7:
  - `words_loaded` counts 0..8.
  - Location 0 reads 0xA0.
  - `core_reset` stays high until HOLD expires.
- With `IMEM_BOUNDS_CHECK_EN`, load 2 words (nop, nop):
  - The fetch at address 2 returns 0x0000000D and `fault`=1.
  - The core halts and `done`=1.
